can_axil_reg_master: RTL

Register-bus-to-AXI4-Lite master bridge for the CAN controller IP. It sits directly downstream of the CAN data transfer unit. It converts that unit's single-word register write and read requests (8-bit offset, enable pulse, busy/done handshake) into AXI4-Lite transactions on the CAN IP slave port. Read data and done pulses are returned upstream. Only one transaction is outstanding at any time.

---
 rtl/can_axil_reg_master_if.sv | 32 +++
 rtl/can_axil_reg_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_axil_reg_master_if.sv
// AXI4-Lite bus between the CAN register bridge and the CAN IP slave port.
//   master modport : driven by the bridge (valids, payloads, B/R ready).
//   slave  modport : driven by the CAN IP (A/W ready, B/R responses).
interface can_axil_reg_master_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/can_axil_reg_master.sv
// Register-bus to AXI4-Lite master bridge for the CAN controller IP.
// Turns single-word register write/read strobes from the CAN data transfer
// unit into AXI4-Lite transactions, one outstanding at a time.
//   sys_clk, reset_n            : clock, async active-low reset
//   wr_addr_in/wr_data_in/wr_enable_in, wr_busy_out, wr_done_out : write port
//   rd_addr_in/rd_enable_in, rd_data_out, rd_busy_out, rd_done_out : read port
//   m_axi                       : AXI4-Lite master port
//   resp_err_out                : sticky, any non-OKAY BRESP/RRESP
//   timeout_err_out             : sticky, any wait state exceeded TIMEOUT_CYCLES
module can_axil_reg_master #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [7:0]  wr_addr_in,
  input  logic [31:0] wr_data_in,
  input  logic        wr_enable_in,
  output logic        wr_busy_out,
  output logic        wr_done_out,
  input  logic [7:0]  rd_addr_in,
  input  logic        rd_enable_in,
  output logic [31:0] rd_data_out,
  output logic        rd_busy_out,
  output logic        rd_done_out,
  output logic        resp_err_out,
  output logic        timeout_err_out,
  can_axil_reg_master_if.master m_axi
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;

  localparam int            CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic          arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          wr_done_q, wr_done_d, rd_done_q, rd_done_d, busy_q, busy_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_addr_q, pend_addr_d;
  logic          resp_err_q, resp_err_d, tmo_err_q, tmo_err_d;
  logic          aw_ok, w_ok, tmo;

  // A channel counts as complete once its valid has dropped, or on the
  // handshake happening this cycle; this counts each beat exactly once
  // whatever order awready/wready arrive in.
  assign aw_ok = !awvalid_q || m_axi.awready;
  assign w_ok  = !wvalid_q  || m_axi.wready;
  assign tmo   = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) && (cnt_q == TMO_MAX);

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rd_data_d   = rd_data_q;
    wr_done_d   = 1'b0;
    rd_done_d   = 1'b0;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    resp_err_d  = resp_err_q;
    tmo_err_d   = tmo_err_q;

    case (state_q)
      ST_IDLE: begin
        // A stored read goes first; new strobes in this cycle are dropped.
        if (pend_q) begin
          pend_d    = 1'b0;
          araddr_d  = BASE_ADDR + {24'd0, pend_addr_q};
          arvalid_d = 1'b1;
          state_d   = ST_RD_REQ;
        end else if (wr_enable_in) begin
          awaddr_d  = BASE_ADDR + {24'd0, wr_addr_in};
          wdata_d   = wr_data_in;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_WR_REQ;
          if (rd_enable_in) begin
            pend_d      = 1'b1;
            pend_addr_d = rd_addr_in;
          end
        end else if (rd_enable_in) begin
          araddr_d  = BASE_ADDR + {24'd0, rd_addr_in};
          arvalid_d = 1'b1;
          state_d   = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d  = 1'b0;
          wr_done_d = 1'b1;
          state_d   = ST_IDLE;
          if (m_axi.bresp != 2'b00) resp_err_d = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (m_axi.rvalid) begin
          rready_d  = 1'b0;
          rd_data_d = m_axi.rdata;
          rd_done_d = 1'b1;
          state_d   = ST_IDLE;
          if (m_axi.rresp != 2'b00) resp_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Fault recovery: abandon the bus transaction and release the upstream
    // unit with a done pulse. A stored pending read is kept.
    if (tmo) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      tmo_err_d = 1'b1;
      state_d   = ST_IDLE;
      if (state_q == ST_WR_REQ || state_q == ST_WR_RESP) begin
        wr_done_d = 1'b1;
      end else begin
        rd_done_d = 1'b1;
        rd_data_d = 32'hDEAD_BEEF;
      end
    end
  end

  // Wait counter restarts on every state change and saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q != ST_IDLE && cnt_q != TMO_MAX)
      cnt_d = cnt_q + CW'(1);
  end

  assign busy_d = (state_d != ST_IDLE) || pend_d;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rd_data_q   <= '0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      resp_err_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rd_data_q   <= rd_data_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      resp_err_q  <= resp_err_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign wr_busy_out     = busy_q;
  assign rd_busy_out     = busy_q;
  assign wr_done_out     = wr_done_q;
  assign rd_done_out     = rd_done_q;
  assign rd_data_out     = rd_data_q;
  assign resp_err_out    = resp_err_q;
  assign timeout_err_out = tmo_err_q;

endmodule
